servant_wb_rr_arbiter: RTL and testbench

SERVANT_WB_RR_ARBITER -- requirements
Module: servant_wb_rr_arbiter

---
 rtl/servant_wb_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_servant_wb_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : servant_wb_rr_arbiter
// Description : Three-master round-robin Wishbone arbiter with a per-transaction
//               slave ack timeout and a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_wb_rr_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   // master 0
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic        i_m0_we,
   input  logic        i_m0_cyc,
   output logic [31:0] o_m0_rdt,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   // master 1
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic        i_m1_we,
   input  logic        i_m1_cyc,
   output logic [31:0] o_m1_rdt,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   // master 2
   input  logic [31:0] i_m2_adr,
   input  logic [31:0] i_m2_dat,
   input  logic [3:0]  i_m2_sel,
   input  logic        i_m2_we,
   input  logic        i_m2_cyc,
   output logic [31:0] o_m2_rdt,
   output logic        o_m2_ack,
   output logic        o_m2_err,
   // slave
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic        o_s_cyc,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   // status
   output logic        o_timeout
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Counter value on the last BUSY cycle allowed before the error fires:
   // the first BUSY cycle sees a count of zero.
   localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [1:0]  r_grant;
   logic [1:0]  r_prio;
   logic [15:0] r_cnt;
   logic        r_timeout;

   logic [2:0]  w_cyc;
   logic        w_gnt_cyc;
   logic        w_active;
   logic        w_done;
   logic        w_expire;
   logic [1:0]  w_idx1;
   logic [1:0]  w_idx2;
   logic [1:0]  w_pick;
   logic [1:0]  w_next_prio;
   logic [2:0]  w_ack_vec;
   logic [2:0]  w_err_vec;
   logic [31:0] w_rdt [3];

   assign w_cyc = {i_m2_cyc, i_m1_cyc, i_m0_cyc};

   // Request line of the currently granted master.
   always_comb begin
      w_gnt_cyc = 1'b0;
      case (r_grant)
         2'd0:    w_gnt_cyc = i_m0_cyc;
         2'd1:    w_gnt_cyc = i_m1_cyc;
         2'd2:    w_gnt_cyc = i_m2_cyc;
         default: w_gnt_cyc = 1'b0;
      endcase
   end

   assign w_active = (r_state == ST_BUSY) && w_gnt_cyc;
   assign w_done   = w_active && i_s_ack;
   // Ack on the expiry cycle wins over the timeout.
   assign w_expire = w_active && !i_s_ack && (r_cnt == C_CNT_LAST);
   assign o_s_cyc  = w_active && !w_expire;

   // Slave request fields follow the granted master.
   always_comb begin
      o_s_adr = i_m0_adr;
      o_s_dat = i_m0_dat;
      o_s_sel = i_m0_sel;
      o_s_we  = i_m0_we;
      case (r_grant)
         2'd1: begin
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
            o_s_sel = i_m1_sel;
            o_s_we  = i_m1_we;
         end
         2'd2: begin
            o_s_adr = i_m2_adr;
            o_s_dat = i_m2_dat;
            o_s_sel = i_m2_sel;
            o_s_we  = i_m2_we;
         end
         default: ;
      endcase
   end

   // Round-robin scan order p, p+1, p+2 (mod 3); pointer only holds 0..2.
   always_comb begin
      w_idx1 = (r_prio == 2'd2) ? 2'd0 : r_prio + 2'd1;
      w_idx2 = (r_prio == 2'd0) ? 2'd2 : r_prio - 2'd1;
      if (w_cyc[r_prio])
         w_pick = r_prio;
      else if (w_cyc[w_idx1])
         w_pick = w_idx1;
      else
         w_pick = w_idx2;
      w_next_prio = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
   end

   // Per-master response routing: only the granted master ever sees data/ack/err.
   for (genvar i = 0; i < 3; i++) begin : g_resp
      assign w_ack_vec[i] = w_done   && (r_grant == 2'(i));
      assign w_err_vec[i] = w_expire && (r_grant == 2'(i));
      assign w_rdt[i]     = (r_grant == 2'(i)) ? i_s_rdt : 32'h0;
   end

   assign o_m0_ack = w_ack_vec[0];
   assign o_m1_ack = w_ack_vec[1];
   assign o_m2_ack = w_ack_vec[2];
   assign o_m0_err = w_err_vec[0];
   assign o_m1_err = w_err_vec[1];
   assign o_m2_err = w_err_vec[2];
   assign o_m0_rdt = w_rdt[0];
   assign o_m1_rdt = w_rdt[1];
   assign o_m2_rdt = w_rdt[2];
   assign o_timeout = r_timeout;

   // Arbitration FSM: grant in IDLE, hold the grant in BUSY until ack, timeout or abandon.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= 2'd0;
         r_prio    <= 2'd0;
         r_cnt     <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_cyc) begin
                  r_grant <= w_pick;
                  r_cnt   <= 16'd0;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_gnt_cyc) begin
                  // Master gave up: no response, pointer left where it was.
                  r_state <= ST_IDLE;
               end else if (i_s_ack) begin
                  r_state <= ST_IDLE;
                  r_prio  <= w_next_prio;
               end else if (w_expire) begin
                  r_state   <= ST_IDLE;
                  r_prio    <= w_next_prio;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_servant_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_wb_rr_arbiter
// Description : Directed self-checking bench for servant_wb_rr_arbiter
//               (instantiated with TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_wb_rr_arbiter;

   localparam logic [31:0] C_ADR0 = 32'h1000_0000;
   localparam logic [31:0] C_ADR1 = 32'h2000_0004;
   localparam logic [31:0] C_ADR2 = 32'h3000_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_adr = C_ADR0, m1_adr = C_ADR1, m2_adr = C_ADR2;
   logic [31:0] m0_dat = 32'hA0A0_0000, m1_dat = 32'hA1A1_1111, m2_dat = 32'hA2A2_2222;
   logic [3:0]  m0_sel = 4'h1, m1_sel = 4'h3, m2_sel = 4'hF;
   logic        m0_we = 1'b1, m1_we = 1'b0, m2_we = 1'b1;
   logic        m0_cyc, m1_cyc, m2_cyc;
   logic [31:0] m0_rdt, m1_rdt, m2_rdt;
   logic        m0_ack, m1_ack, m2_ack;
   logic        m0_err, m1_err, m2_err;
   logic [31:0] s_adr, s_dat;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc;
   logic [31:0] s_rdt;
   logic        s_ack;
   logic        timeout;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] adr_tab [3];

   servant_wb_rr_arbiter #(.TIMEOUT(4)) dut (
      .wb_clk(clk), .wb_rst(rst),
      .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_cyc(m0_cyc),
      .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
      .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_cyc(m1_cyc),
      .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
      .i_m2_adr(m2_adr), .i_m2_dat(m2_dat), .i_m2_sel(m2_sel), .i_m2_we(m2_we), .i_m2_cyc(m2_cyc),
      .o_m2_rdt(m2_rdt), .o_m2_ack(m2_ack), .o_m2_err(m2_err),
      .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
      .i_s_rdt(s_rdt), .i_s_ack(s_ack),
      .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Sample point: falling edge, away from the active edge.
   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [2:0] acks();
      return {m2_ack, m1_ack, m0_ack};
   endfunction

   function automatic logic [2:0] errs();
      return {m2_err, m1_err, m0_err};
   endfunction

   // From IDLE with requests present: one idle cycle, `waits` BUSY cycles without
   // ack, then an acked BUSY cycle; checks grant via slave address and ack pulse.
   task automatic run_txn(input string tag, input int m, input int waits);
      s_ack = 1'b0;
      sample();
      check({tag, "_idle_cyc"}, {31'd0, s_cyc}, 32'd0);
      check({tag, "_idle_ack"}, {29'd0, acks()}, 32'd0);
      next();
      for (int k = 0; k < waits; k++) begin
         sample();
         check({tag, "_busy_cyc"}, {31'd0, s_cyc}, 32'd1);
         check({tag, "_busy_adr"}, s_adr, adr_tab[m]);
         check({tag, "_busy_ack"}, {29'd0, acks()}, 32'd0);
         next();
      end
      s_ack = 1'b1;
      sample();
      check({tag, "_ack"}, {29'd0, acks()}, 32'(3'b001 << m));
      check({tag, "_ack_err"}, {29'd0, errs()}, 32'd0);
      next();
      s_ack = 1'b0;
   endtask

   initial begin
      adr_tab[0] = C_ADR0;
      adr_tab[1] = C_ADR1;
      adr_tab[2] = C_ADR2;
      rst = 1'b1;
      m0_cyc = 1'b0; m1_cyc = 1'b0; m2_cyc = 1'b0;
      s_ack = 1'b0; s_rdt = 32'h0;

      // Reset state
      repeat (2) next();
      sample();
      check("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_acks", {29'd0, acks()}, 32'd0);
      next();
      rst = 1'b0;

      // Ack while idle is ignored
      s_ack = 1'b1;
      sample();
      check("idle_ack_ignored", {29'd0, acks()}, 32'd0);
      next();
      s_ack = 1'b0;

      // All three requesting: grants m0, m1, m2, m0
      m0_cyc = 1'b1; m1_cyc = 1'b1; m2_cyc = 1'b1;
      run_txn("rr0", 0, 1);
      run_txn("rr1", 1, 1);
      run_txn("rr2", 2, 1);
      run_txn("rr3", 0, 1);   // pointer now 1
      m0_cyc = 1'b0; m1_cyc = 1'b0; m2_cyc = 1'b0;
      sample();
      check("post_rr_acks", {29'd0, acks()}, 32'd0);
      next();

      // Read data routing for m1
      m1_cyc = 1'b1;
      next();                 // IDLE cycle consumed
      s_rdt = 32'hDEAD_BEEF;
      s_ack = 1'b1;
      sample();
      check("rd_m1_rdt", m1_rdt, 32'hDEAD_BEEF);
      check("rd_m1_ack", {31'd0, m1_ack}, 32'd1);
      check("rd_m0_rdt", m0_rdt, 32'h0);
      check("rd_m2_rdt", m2_rdt, 32'h0);
      next();                 // pointer now 2
      s_ack = 1'b0; s_rdt = 32'h0;
      m1_cyc = 1'b0;

      // Timeout on m2 (TIMEOUT=4): err on the 4th BUSY cycle
      m2_cyc = 1'b1;
      next();
      for (int k = 1; k <= 3; k++) begin
         sample();
         check("to_pre_err", {29'd0, errs()}, 32'd0);
         check("to_pre_cyc", {31'd0, s_cyc}, 32'd1);
         next();
      end
      sample();
      check("to_err", {29'd0, errs()}, 32'b100);
      check("to_cyc_drop", {31'd0, s_cyc}, 32'd0);
      check("to_flag_pre", {31'd0, timeout}, 32'd0);
      next();
      m2_cyc = 1'b0;
      sample();
      check("to_err_pulse", {29'd0, errs()}, 32'd0);
      check("to_flag_set", {31'd0, timeout}, 32'd1);
      next();
      // Next grant after m2 timeout goes to m0 (m0 and m2 both asking)
      m0_cyc = 1'b1; m2_cyc = 1'b1;
      run_txn("after_to", 0, 0);
      m0_cyc = 1'b0; m2_cyc = 1'b0;
      sample();
      check("to_flag_sticky", {31'd0, timeout}, 32'd1);
      next();

      // Reset clears sticky flag; then ack arriving on 4th BUSY cycle wins
      rst = 1'b1;
      next();
      rst = 1'b0;
      sample();
      check("rst2_timeout", {31'd0, timeout}, 32'd0);
      m0_cyc = 1'b1;
      next();                 // IDLE cycle
      repeat (3) next();      // BUSY cycles 1..3
      s_ack = 1'b1;
      sample();
      check("race_ack", {29'd0, acks()}, 32'b001);
      check("race_err", {29'd0, errs()}, 32'd0);
      check("race_cyc", {31'd0, s_cyc}, 32'd1);
      next();                 // pointer now 1
      s_ack = 1'b0; m0_cyc = 1'b0;
      sample();
      check("race_flag", {31'd0, timeout}, 32'd0);
      next();

      // Reset mid-BUSY of m1, then m1 and m2 pending -> m1 (scan from 0)
      m1_cyc = 1'b1;
      next();
      sample();
      check("midrst_busy", {31'd0, s_cyc}, 32'd1);
      check("midrst_adr", s_adr, C_ADR1);
      s_ack = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("midrst_cyc0", {31'd0, s_cyc}, 32'd0);
      check("midrst_noack", {29'd0, acks()}, 32'd0);
      next();
      s_ack = 1'b0;
      rst = 1'b0;
      m2_cyc = 1'b1;
      run_txn("postrst", 1, 0);  // pointer now 2
      m1_cyc = 1'b0; m2_cyc = 1'b0;
      next();

      // m0 abandons mid-BUSY; pending m1 granted one cycle later
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      next();                 // IDLE: scan 2,0,1 -> m0
      sample();
      check("drop_grant", s_adr, C_ADR0);
      check("drop_busy", {31'd0, s_cyc}, 32'd1);
      next();
      m0_cyc = 1'b0;
      sample();
      check("drop_cyc", {31'd0, s_cyc}, 32'd0);
      check("drop_noack", {29'd0, acks()}, 32'd0);
      check("drop_noerr", {29'd0, errs()}, 32'd0);
      next();                 // back in IDLE
      sample();
      check("drop_idle", {31'd0, s_cyc}, 32'd0);
      next();
      sample();
      check("drop_m1_cyc", {31'd0, s_cyc}, 32'd1);
      check("drop_m1_adr", s_adr, C_ADR1);
      check("drop_m1_we", {31'd0, s_we}, 32'd0);
      check("drop_m1_sel", {28'd0, s_sel}, 32'h3);
      s_ack = 1'b1;
      sample();
      next();
      s_ack = 1'b0; m1_cyc = 1'b0;
      next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog: the bench never hangs.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
